// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, per-scan
// debounce FSM and a one-entry valid/ready keycode buffer.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   row_n[3:0]  keypad rows, low = closed in driven column
//   col_n[3:0]  one-hot active-low column drive
//   key_code    {row_idx, col_idx}, stable while key_valid
//   key_valid   keycode available, held until accepted
//   key_ready   consumer accept
//   key_drop    1-clk pulse: accepted press lost, buffer full
//   key_held    debounced key-down level
//
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat.
module keypad_scanner #(
  parameter int SCAN_DIV   = 10000,
  parameter int DEB_SCANS  = 4,
  parameter int REPEAT_DLY = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_drop,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SCANS);
  localparam bit DEB1 = (DEB_SCANS == 1);

  if (SCAN_DIV < 4 || REPEAT_DLY < DEB_SCANS) begin : g_cfg_chk
    $error("keypad_scanner: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, DEB, PRESSED, REL
  } state_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [3:0]    r_col_n;
  logic [1:0]    r_acc_n;
  logic [3:0]    r_acc_code;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_code;
  logic          r_valid, r_drop, r_held;

  logic          w_last, w_scan_end;
  logic [3:0]    w_hit;
  logic [2:0]    w_nhit, w_tot;
  logic [1:0]    w_row;
  logic          w_none, w_one, w_match;
  logic [3:0]    w_code;
  logic [CW-1:0] w_cnt_inc;
  logic          w_deb_hit, w_take, w_accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);
  logic [RW-1:0] r_rpt;
  logic          w_rpt_hit;
  assign w_rpt_hit = (r_rpt + 1'b1) == RW'(REPEAT_DLY);
`endif

  assign w_last     = (r_div == DIV_LAST);
  assign w_scan_end = w_last && (r_col == 2'd3);
  assign w_hit      = ~r_sync2;
  assign w_nhit     = {2'b0, w_hit[0]} + {2'b0, w_hit[1]}
                    + {2'b0, w_hit[2]} + {2'b0, w_hit[3]};

  always_comb begin
    w_row = 2'd0;
    if (w_hit[1]) w_row = 2'd1;
    if (w_hit[2]) w_row = 2'd2;
    if (w_hit[3]) w_row = 2'd3;
  end

  // Scan result combines earlier columns with the column sampled now.
  assign w_tot     = {1'b0, r_acc_n} + w_nhit;
  assign w_none    = (w_tot == 3'd0);
  assign w_one     = (w_tot == 3'd1);
  assign w_code    = (w_nhit == 3'd1) ? {w_row, r_col} : r_acc_code;
  assign w_match   = (w_code == r_cand);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_deb_hit = (w_cnt_inc == CNT_LAST);
  assign w_take    = r_valid && key_ready;

  always_comb begin
    w_accept = 1'b0;
    if (w_scan_end && w_one) begin
      case (r_state)
        IDLE:    w_accept = DEB1;
        DEB:     w_accept = w_match && w_deb_hit;
`ifdef KEYPAD_REPEAT_EN
        PRESSED: w_accept = w_match && w_rpt_hit;
`endif
        default: w_accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_div      <= '0;
      r_col      <= 2'd0;
      r_col_n    <= 4'b1110;
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
      if (w_last) begin
        r_div   <= '0;
        r_col   <= r_col + 1'b1;
        r_col_n <= {r_col_n[2:0], r_col_n[3]};
        if (w_scan_end) begin
          r_acc_n    <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_n <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
          if (w_nhit == 3'd1)
            r_acc_code <= {w_row, r_col};
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt   <= '0;
`endif
    end else begin
      // A handshake on the accept edge frees the slot for the new key.
      r_drop <= w_accept && r_valid && !w_take;
      if (w_accept && (!r_valid || w_take)) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
      if (w_scan_end) begin
        case (r_state)
          IDLE: begin
            if (w_one) begin
              r_cand <= w_code;
              if (DEB1) begin
                r_state <= PRESSED;
                r_held  <= 1'b1;
              end else begin
                r_state <= DEB;
                r_cnt   <= CW'(1);
              end
            end
          end
          DEB: begin
            if (!w_one) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (!w_match) begin
              r_cand <= w_code;
              r_cnt  <= CW'(1);
            end else if (w_deb_hit) begin
              r_state <= PRESSED;
              r_held  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          PRESSED: begin
            if (w_none) begin
`ifdef KEYPAD_REPEAT_EN
              r_rpt <= '0;
`endif
              if (DEB1) begin
                r_state <= IDLE;
                r_held  <= 1'b0;
              end else begin
                r_state <= REL;
                r_cnt   <= CW'(1);
              end
            end
`ifdef KEYPAD_REPEAT_EN
            // After the first repeat, rewind so the next
            // one lands DEB_SCANS scans later.
            else if (w_one && w_match) begin
              r_rpt <= w_rpt_hit
                     ? RW'(REPEAT_DLY - DEB_SCANS)
                     : r_rpt + 1'b1;
            end
`endif
          end
          REL: begin
            if (!w_none) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
            end else if (w_deb_hit) begin
              r_state <= IDLE;
              r_held  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign col_n     = r_col_n;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_drop  = r_drop;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed keypad scenarios plus
// random per-scan key patterns against a scan-level model.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int RD   = 6;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_drop;
  logic       key_held;

  logic [15:0] keys = '0;
  logic        bnc_en = 1'b0;
  logic        bnc_val = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drops = 0;
  logic [3:0] obs[$];
  logic [3:0] exp_q[$];
  int res[$];

  int n0, d0, k, a, b, len, hot;
  logic [15:0] pat;
  bit found;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SD), .DEB_SCANS(DS), .REPEAT_DLY(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n),
    .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_drop(key_drop), .key_held(key_held)
  );

  // Ideal switch matrix: a row reads low when a pressed key
  // sits in the currently driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    if (bnc_en) row_n[1] = bnc_val;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n) begin
      if (key_valid && key_ready) obs.push_back(key_code);
      if (key_drop) drops++;
    end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic align();
    @(posedge clk); #1;
    while (cyc % SCAN != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] last_obs();
    if (obs.size() == 0) return 4'hx;
    return obs[obs.size()-1];
  endfunction

  function automatic int scan_of(input logic [15:0] p);
    int idx = 0;
    if ($countones(p) == 0) return -1;
    if ($countones(p) > 1) return -2;
    for (int i = 0; i < 16; i++) if (p[i]) idx = i;
    return idx;
  endfunction

  // Up: need DS identical single-key scans in a row.
  // Down: need DS empty scans in a row to release.
  function automatic void run_model();
    bit down = 0;
    int last = -1, run = 0, quiet = 0, held = 0, key = 0;
    foreach (res[i]) begin
      int s = res[i];
      if (!down) begin
        if (s >= 0) begin
          run = (s == last) ? run + 1 : 1;
          last = s;
          if (run == DS) begin
            down = 1; key = s; quiet = 0; held = 0;
            exp_q.push_back(4'(s));
          end
        end else begin
          run = 0; last = -1;
        end
      end else if (s == -1) begin
        quiet++; held = 0;
        if (quiet == DS) begin
          down = 0; run = 0; last = -1;
        end
      end else begin
        if (quiet == 0 && s == key) begin
          held++;
`ifdef KEYPAD_REPEAT_EN
          if (held == RD || (held > RD && (held - RD) % DS == 0))
            exp_q.push_back(4'(key));
`endif
        end
        quiet = 0;
      end
    end
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col_n, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_drop", key_drop, 0);
    check("rst_held", key_held, 0);
    @(negedge clk) rst_n = 1'b1;

    // single press, latency and one-clock valid
    align();
    key_ready = 1'b1;
    n0 = obs.size();
    keys[6] = 1'b1;
    found = 0;
    for (int i = 0; i < 67; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1;
        break;
      end
    end
    check("t2_latency", found, 1);
    check("t2_code", key_code, 4'h6);
    @(negedge clk);
    check("t2_pulse", key_valid, 0);
    align();
    scans(17);
    check("t2_once", obs.size() - n0, 1);
    check("t2_held", key_held, 1);
    keys = '0;
    scans(5);
    check("t2_rel", key_held, 0);

    // bounce on row1 then steady key 6
    n0 = obs.size();
    keys[6] = 1'b1;
    bnc_en = 1'b1;
    bnc_val = 1'b0;
    repeat (8) begin
      repeat (5) @(posedge clk);
      #1 bnc_val = ~bnc_val;
    end
    check("t3_quiet", obs.size() - n0, 0);
    bnc_en = 1'b0;
    align();
    scans(6);
    check("t3_once", obs.size() - n0, 1);
    check("t3_code", last_obs(), 4'h6);
    keys = '0;
    scans(5);

    // backpressure: second press dropped
    key_ready = 1'b0;
    n0 = obs.size();
    d0 = drops;
    keys[3] = 1'b1;
    scans(5);
    check("t4_valid", key_valid, 1);
    check("t4_code3", key_code, 4'h3);
    keys = '0;
    scans(5);
    keys[12] = 1'b1;
    scans(5);
    check("t4_drop", drops - d0, 1);
    check("t4_hold", key_code, 4'h3);
    key_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_fall", key_valid, 0);
    check("t4_take", obs.size() - n0, 1);
    check("t4_tcode", last_obs(), 4'h3);
    keys = '0;
    align();
    scans(5);

    // two keys pressed, then one released
    n0 = obs.size();
    keys[0] = 1'b1;
    keys[9] = 1'b1;
    scans(5);
    check("t5_none", obs.size() - n0, 0);
    check("t5_nheld", key_held, 0);
    keys[9] = 1'b0;
    scans(5);
    check("t5_one", obs.size() - n0, 1);
    check("t5_code", last_obs(), 4'h0);
    keys = '0;
    scans(5);

    // long hold of key 9
    n0 = obs.size();
    keys[9] = 1'b1;
    scans(15);
    repeat (4) @(posedge clk);
    #1;
`ifdef KEYPAD_REPEAT_EN
    check("t6_count", obs.size() - n0, 4);
`else
    check("t6_count", obs.size() - n0, 1);
`endif
    check("t6_code", last_obs(), 4'h9);
    align();
    keys = '0;
    scans(5);

    // reset mid-scan with a key pending
    key_ready = 1'b0;
    keys[5] = 1'b1;
    scans(4);
    check("t1_pend", key_valid, 1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t1_col", col_n, 4'b1110);
    check("t1_valid", key_valid, 0);
    check("t1_held", key_held, 0);
    check("t1_drop", key_drop, 0);
    check("t1_code", key_code, 0);
    keys = '0;
    @(negedge clk) rst_n = 1'b1;

    // random patterns, constant within each scan
    align();
    key_ready = 1'b1;
    n0 = obs.size();
    d0 = drops;
    hot = 0;
    repeat (40) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        pat = '0;
      end else if (k < 8) begin
        if ($urandom_range(0, 2) == 0) hot = $urandom_range(0, 15);
        pat = 16'd1 << hot;
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        pat = (16'd1 << a) | (16'd1 << b);
      end
      len = $urandom_range(1, 6);
      repeat (len) begin
        keys = pat;
        res.push_back(scan_of(pat));
        scans(1);
      end
    end
    repeat (5) begin
      keys = '0;
      res.push_back(-1);
      scans(1);
    end
    run_model();
    check("rnd_count", obs.size() - n0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("rnd_key",
            (n0 + i < obs.size()) ? obs[n0+i] : 4'hx,
            exp_q[i]);
    check("rnd_drop", drops - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
